// File: rtl/lfsr_encrypt_engine_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_encrypt_engine_pkg
//   Shared definitions for the LFSR stream-encryption engine: frame FSM state
//   encoding, frame/padding constants and the per-byte cipher helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package lfsr_encrypt_engine_pkg;

    localparam int         FRAME_LEN   = 64;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int         PRE_MIN     = 10;
    localparam int         PRE_MAX     = 15;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        MSG,
        POST,
        DONE
    } state_t;

    // Leading-space count is held inside [PRE_MIN, PRE_MAX].
    function automatic logic [3:0] clamp_pre(input logic [3:0] len);
        if (int'(len) < PRE_MIN) begin
            return 4'(PRE_MIN);
        end
        if (int'(len) > PRE_MAX) begin
            return 4'(PRE_MAX);
        end
        return len;
    endfunction

    // Shift printable ASCII down so a space maps to zero, mask with the key
    // stream and prepend an even-parity bit over the 7-bit cipher.
    function automatic logic [7:0] encrypt_byte(input logic [6:0] plain,
                                                 input logic [6:0] key);
        logic [6:0] c;
        c = (plain - ASCII_SPACE[6:0]) ^ key;
        return {^c, c};
    endfunction

endpackage

// File: rtl/lfsr_encrypt_engine_lfsr7.sv
// -----------------------------------------------------------------------------
// lfsr7
//   7-bit Fibonacci-style LFSR with a runtime tap mask. Shifts left; the new
//   LSB is the XOR of the state bits selected by ptrn.
// Ports:
//   clk      in   system clock
//   init     in   synchronous active-high clear (state -> 0)
//   load     in   load load_val into the state
//   load_val in   [6:0] seed value
//   ptrn     in   [6:0] feedback tap mask
//   adv      in   advance one step
//   state    out  [6:0] current LFSR value
// -----------------------------------------------------------------------------
module lfsr7 (
    input  logic       clk,
    input  logic       init,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic [6:0] ptrn,
    input  logic       adv,
    output logic [6:0] state
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (init) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (adv) begin
            state <= {state[5:0], ^(state & ptrn)};
        end
    end

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// -----------------------------------------------------------------------------
// lfsr_encrypt_engine
//   Frames a plaintext ASCII message into FRAME_LEN ciphertext bytes:
//   pre_length leading spaces, the message, then trailing spaces. Each byte is
//   masked with an LFSR key stream and carries even parity in bit 7.
// Ports:
//   clk        in   system clock, rising edge
//   init       in   synchronous active-high reset / frame abort
//   req        in   start pulse, honoured only in IDLE
//   lfsr_ptrn  in   [6:0] LFSR tap mask, latched on req
//   lfsr_init  in   [6:0] LFSR seed (0 means 7'h01), latched on req
//   pre_length in   [3:0] leading-space count (clamped 10..15), latched on req
//   in_data    in   [7:0] plaintext byte
//   in_valid   in   plaintext byte valid
//   in_last    in   final plaintext byte of the message
//   in_ready   out  plaintext byte can be taken this cycle
//   out_data   out  [7:0] ciphertext byte, parity in bit 7
//   out_valid  out  ciphertext byte valid
//   out_ready  in   downstream accepts the ciphertext byte
//   ack        out  one-cycle pulse after the last byte of a frame is accepted
// -----------------------------------------------------------------------------
module lfsr_encrypt_engine
    import lfsr_encrypt_engine_pkg::*;
#(
    parameter int FRAME_LEN = lfsr_encrypt_engine_pkg::FRAME_LEN
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    input  logic [6:0] lfsr_ptrn,
    input  logic [6:0] lfsr_init,
    input  logic [3:0] pre_length,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ack
);

    localparam int               POS_W    = $clog2(FRAME_LEN + 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);
    // Position counter parks here once every byte of the frame is emitted.
    localparam logic [POS_W-1:0] END_POS  = POS_W'(FRAME_LEN);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    state_t           state;
    logic [6:0]       ptrn_q;
    logic [3:0]       pre_q;
    logic [POS_W-1:0] pos;
    logic [6:0]       key;

    logic             can_load;
    logic             out_accept;
    logic             emit;
    logic             start;
    logic             frame_full;
    logic [6:0]       plain;
    logic [6:0]       seed;
    logic             unused_in_msb;

    // The cipher works on 7-bit ASCII; bit 7 of the plaintext has no effect.
    assign unused_in_msb = in_data[7];

    assign out_accept = out_valid && out_ready;
    assign can_load   = !out_valid || out_ready;
    assign frame_full = (pos == END_POS);
    assign start      = !init && (state == IDLE) && req;
    assign seed       = (lfsr_init == 7'd0) ? 7'h01 : lfsr_init;
    assign plain      = (state == MSG) ? in_data[6:0] : ASCII_SPACE[6:0];

    // Combinational so a byte can be taken in the same cycle the output
    // register drains.
    assign in_ready = !init && (state == MSG) && !frame_full && can_load;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        emit = 1'b0;
        if (!init && !frame_full) begin
            case (state)
                PRE, POST: emit = can_load;
                MSG:       emit = can_load && in_valid;
                default:   emit = 1'b0;
            endcase
        end
    end

    lfsr7 u_lfsr (
        .clk      (clk),
        .init     (init),
        .load     (start),
        .load_val (seed),
        .ptrn     (ptrn_q),
        .adv      (emit),
        .state    (key)
    );

    // NOTE: the output data register is reset explicitly because its reset
    // value is architecturally visible, not just a don't-care behind valid.
    always_ff @(posedge clk) begin
        if (init) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            ack       <= 1'b0;
            pos       <= '0;
            ptrn_q    <= '0;
            pre_q     <= 4'(PRE_MIN);
        end else begin
            ack <= 1'b0;

            // Single output stage: load a new byte, or drain on acceptance.
            if (emit) begin
                out_data  <= encrypt_byte(plain, key);
                out_valid <= 1'b1;
                pos       <= pos + POS_ONE;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        ptrn_q <= lfsr_ptrn;
                        pre_q  <= clamp_pre(pre_length);
                        pos    <= '0;
                        state  <= PRE;
                    end
                end
                PRE: begin
                    if (emit && pos == POS_W'(pre_q - 4'd1)) begin
                        state <= MSG;
                    end
                end
                MSG: begin
                    // in_last on the final position needs no padding phase;
                    // the frame just drains. Either end condition alone moves
                    // to padding (trailing spaces, or a pure drain).
                    if (emit && (in_last || pos == LAST_POS)
                             && !(in_last && pos == LAST_POS)) begin
                        state <= POST;
                    end
                end
                POST: begin
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Frame ends once the last emitted byte leaves the output stage.
            if ((state inside {PRE, MSG, POST}) && frame_full && out_accept) begin
                state <= DONE;
                ack   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// -----------------------------------------------------------------------------
// tb_lfsr_encrypt_engine
//   Self-checking bench: a behavioural model builds the expected 64-byte
//   ciphertext of each frame from the configuration and message; a monitor
//   compares every accepted output byte against it.
// -----------------------------------------------------------------------------
module tb_lfsr_encrypt_engine;

    localparam int FL = 64;

    logic       clk;
    logic       init;
    logic       req;
    logic [6:0] lfsr_ptrn;
    logic [6:0] lfsr_init;
    logic [3:0] pre_length;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       ack;

    lfsr_encrypt_engine #(.FRAME_LEN(FL)) dut (
        .clk        (clk),
        .init       (init),
        .req        (req),
        .lfsr_ptrn  (lfsr_ptrn),
        .lfsr_init  (lfsr_init),
        .pre_length (pre_length),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ack        (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got [FL];
    logic [7:0] ref_got [FL];
    int         got_pos = 0;
    int         ack_cnt = 0;
    logic [7:0] msg [FL];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int eff_pre(input int pre);
        return (pre < 10) ? 10 : pre;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Key for position i: seed (0 -> 1), then i steps of "double, drop bit 7,
    // add parity of the tapped bits".
    function automatic logic [6:0] lfsr_at(input logic [6:0] seed,
                                           input logic [6:0] taps, input int i);
        int unsigned v;
        v = (seed == 7'd0) ? 1 : int'(seed);
        for (int k = 0; k < i; k++) begin
            v = ((v * 2) % 128) + ($countones(v & int'(taps)) % 2);
        end
        return 7'(v);
    endfunction

    task automatic build_model(input logic [6:0] taps, input logic [6:0] seed,
                               input int pre, input int msg_len);
        int p_eff;
        int take;
        int unsigned plain;
        int unsigned c;
        p_eff = eff_pre(pre);
        take  = min2(msg_len, FL - p_eff);
        exp_q.delete();
        for (int i = 0; i < FL; i++) begin
            plain = 32;
            if (i >= p_eff && (i - p_eff) < take) plain = int'(msg[i - p_eff]);
            c = ((plain + 256 - 32) % 128) ^ int'(lfsr_at(seed, taps, i));
            exp_q.push_back(8'(($countones(c) % 2) * 128 + c));
        end
    endtask

    // Position of the first non-space plaintext, recovered from DUT bytes.
    function automatic int first_nonspace(input logic [6:0] seed, input logic [6:0] taps);
        for (int i = 0; i < FL; i++) begin
            if ((got[i][6:0] ^ lfsr_at(seed, taps, i)) != 7'd0) return i;
        end
        return -1;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!init && prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
        end
        if (!init && out_valid && out_ready) begin
            check("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check($sformatf("byte%0d", got_pos), out_data, exp_q.pop_front());
                if (got_pos < FL) got[got_pos] = out_data;
                got_pos++;
            end
        end
        if (ack) begin
            check("ack_after_last", exp_q.size(), 0);
            check("ack_width", prev_ack, 0);
            ack_cnt++;
        end
        prev_stall = out_valid && !out_ready && !init;
        prev_data  = out_data;
        prev_ack   = ack;
    end

    // ---------------- driver ----------------
    task automatic run_frame(input logic [6:0] taps, input logic [6:0] seed,
                             input logic [3:0] pre, input int msg_len,
                             input bit has_last, input bit rnd,
                             input int abort_at, output int cycles);
        int consumed;
        int exp_take;
        int late_ready;
        int ack0;
        int iter;
        bit done;
        build_model(taps, seed, int'(pre), msg_len);
        exp_take = min2(msg_len, FL - eff_pre(int'(pre)));
        got_pos  = 0;
        ack0     = ack_cnt;
        cycles   = 0;

        @(posedge clk); #1;
        req = 1'b1; lfsr_ptrn = taps; lfsr_init = seed; pre_length = pre;
        @(posedge clk); #1;
        req = 1'b0;
        lfsr_ptrn = 7'($urandom); lfsr_init = 7'($urandom); pre_length = 4'($urandom);
        @(negedge clk);
        check("latency_pre", out_valid, 0);

        consumed = 0; late_ready = 0; done = 0; iter = 0;
        while (!done && iter < 4000) begin
            @(posedge clk); #1;
            iter++;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (consumed < msg_len) begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = msg[consumed];
                in_last  = has_last && (consumed == msg_len - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'($urandom);
            end
            req        = rnd && ($urandom_range(0, 7) == 0);
            lfsr_ptrn  = 7'($urandom);
            lfsr_init  = 7'($urandom);
            pre_length = 4'($urandom);
            if (abort_at >= 0 && got_pos >= abort_at) init = 1'b1;
            @(negedge clk);
            if (iter == 1) check("latency_first", out_valid, 1);
            if (init) begin
                check("abort_in_ready", in_ready, 0);
                @(posedge clk); #1;
                init = 1'b0; req = 1'b0; in_valid = 1'b0; in_last = 1'b0;
                @(negedge clk);
                check("abort_out_valid", out_valid, 0);
                check("abort_out_data", out_data, 0);
                check("abort_ack", ack, 0);
                repeat (3) @(negedge clk);
                check("abort_no_ack", ack_cnt - ack0, 0);
                check("abort_idle_valid", out_valid, 0);
                exp_q.delete();
                cycles = iter;
                return;
            end
            if (consumed >= exp_take && in_ready) late_ready++;
            if (in_valid && in_ready) consumed++;
            if (ack) done = 1;
        end
        check("frame_done", done, 1);
        check("consumed", consumed, exp_take);
        check("late_in_ready", late_ready, 0);
        @(posedge clk); #1;
        req = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("ack_count", ack_cnt - ack0, 1);
        check("bytes_left", exp_q.size(), 0);
        check("idle_in_ready", in_ready, 0);
        check("idle_ack", ack, 0);
        cycles = iter;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int diffs;
        int len;
        logic [6:0] taps;
        logic [6:0] seed;
        logic [3:0] pre;
        bit last;

        init = 1'b1; req = 1'b0; lfsr_ptrn = '0; lfsr_init = '0; pre_length = '0;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_ack", ack, 0);
        @(posedge clk); #1;
        init = 1'b0;

        // Reference frame with hand-computed bytes.
        msg[0] = 8'h41;
        run_frame(7'h60, 7'h01, 4'd10, 1, 1, 0, -1, cyc);
        check("ref_byte0", got[0], 8'h81);
        check("ref_byte1", got[1], 8'h82);
        check("ref_byte2", got[2], 8'h84);
        check("ref_byte10", got[10], 8'h39);
        check("ref_cycles", cyc, FL + 1);
        for (int i = 0; i < FL; i++) ref_got[i] = got[i];

        // Zero seed behaves as seed 1.
        run_frame(7'h60, 7'h00, 4'd10, 1, 1, 0, -1, cyc);
        diffs = 0;
        for (int i = 0; i < FL; i++) if (got[i] !== ref_got[i]) diffs++;
        check("seed0_matches_seed1", diffs, 0);

        // Leading-space clamp.
        for (int i = 0; i < 8; i++) msg[i] = 8'($urandom_range(65, 90));
        run_frame(7'h5A, 7'h33, 4'd3, 8, 1, 0, -1, cyc);
        check("first_msg_pos_pre3", first_nonspace(7'h33, 7'h5A), 10);
        run_frame(7'h5A, 7'h33, 4'd15, 8, 1, 0, -1, cyc);
        check("first_msg_pos_pre15", first_nonspace(7'h33, 7'h5A), 15);

        // Over-long message without in_last.
        for (int i = 0; i < 60; i++) msg[i] = 8'($urandom_range(32, 126));
        run_frame(7'h71, 7'h2C, 4'd10, 60, 0, 0, -1, cyc);
        check("long_cycles", cyc, FL + 1);

        // in_last exactly on the final position.
        for (int i = 0; i < 52; i++) msg[i] = 8'($urandom_range(32, 126));
        run_frame(7'h44, 7'h15, 4'd12, 52, 1, 0, -1, cyc);
        check("last_at_end_cycles", cyc, FL + 1);

        // Randomised frames with back-pressure and input gaps.
        for (int f = 0; f < 6; f++) begin
            taps = 7'($urandom);
            seed = (f == 2) ? 7'h00 : 7'($urandom);
            pre  = 4'($urandom);
            len  = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(32, 126));
            last = (len >= FL - eff_pre(int'(pre))) ? 1'($urandom_range(0, 1)) : 1'b1;
            run_frame(taps, seed, pre, len, last, 1, -1, cyc);
        end

        // Abort mid-frame, then a fresh frame.
        for (int i = 0; i < 40; i++) msg[i] = 8'($urandom_range(32, 126));
        run_frame(7'h63, 7'h2A, 4'd11, 40, 1, 0, 30, cyc);
        run_frame(7'h63, 7'h2A, 4'd11, 40, 1, 0, -1, cyc);
        check("fresh_cycles", cyc, FL + 1);

        // init wins over req in the same cycle.
        @(posedge clk); #1;
        init = 1'b1; req = 1'b1; lfsr_ptrn = 7'h60; lfsr_init = 7'h01; pre_length = 4'd10;
        @(posedge clk); #1;
        init = 1'b0; req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("init_over_req", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_encrypt_engine.md
LFSR_ENCRYPT_ENGINE -- requirements
Module: lfsr_encrypt_engine

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: init  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: req  input  1  start pulse; sampled only in IDLE.
REQ-004 SHALL have port: lfsr_ptrn  input  7  feedback tap mask; latched on accepted req.
REQ-005 SHALL have port: lfsr_init  input  7  LFSR start state; latched on accepted req.
REQ-006 SHALL have port: pre_length  input  4  leading-space count; latched on accepted req.
REQ-007 SHALL have ports: in_data  input  8; in_valid  input  1; in_last  input  1; in_ready  output  1. Together these form the plaintext ASCII stream.
REQ-008 SHALL have ports: out_data  output  8; out_valid  output  1; out_ready  input  1. Together these form the ciphertext stream, parity in bit 7.
REQ-009 SHALL have port: ack  output  1  asserted once per frame, with a duration of one cycle, after byte 63 is accepted.
REQ-010 SHALL have parameter: FRAME_LEN, default 64, the number of output bytes per frame.

Function
REQ-011 Each frame SHALL emit exactly FRAME_LEN bytes, then return to IDLE.
REQ-012 The FSM SHALL have the states IDLE, PRE, MSG, POST and DONE.
- IDLE -> PRE on req.
- PRE -> MSG after the pre_length-th byte is emitted.
- MSG -> POST on an accepted in_last byte, or when byte FRAME_LEN-1 is emitted.
- POST -> DONE when byte FRAME_LEN-1 is emitted.
- DONE -> IDLE after one cycle, with ack=1.
REQ-013 Latched pre_length SHALL be clamped: values below 10 become 10, and 15 is the maximum.
REQ-014 If latched lfsr_init is 0, the engine SHALL substitute 7'h01.
REQ-015 The plaintext source per position SHALL be:
- 0x20 in PRE and POST.
- The in_data byte in MSG.
REQ-016 Encryption of position i SHALL be c = (p - 8'h20)[6:0] XOR lfsr[i], and out_data = {^c, c} (even parity over all 8 bits).
REQ-017 LFSR advance SHALL occur once per emitted byte, as lfsr[i+1] = {lfsr[i][5:0], ^(lfsr[i] & lfsr_ptrn)}; lfsr[0] = latched init.
REQ-018 The output SHALL be a single register stage.
- out_valid and out_data SHALL hold stable while out_valid && !out_ready.
- A byte is accepted when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 only in MSG, and only when the output register is empty or being accepted that cycle; an input byte is consumed on in_valid && in_ready.
REQ-020 In MSG with in_valid=0, the engine SHALL stall (no emission, no LFSR advance); spaces are never inserted mid-message.
REQ-021 Message bytes beyond position FRAME_LEN-1 SHALL NOT be accepted; in_ready stays 0 until the next frame.
REQ-022 in_last on the byte at position FRAME_LEN-1 SHALL go directly to DONE.
REQ-023 req outside IDLE SHALL be ignored, and configuration inputs SHALL be ignored mid-frame.
REQ-024 Throughput SHALL be one byte per cycle with out_ready held high; the first out_valid appears 1 cycle after the accepted req.

Reset
REQ-025 When init=1, the engine SHALL force IDLE, out_valid=0, out_data=0, in_ready=0, ack=0, and clear the position counter and LFSR.
REQ-026 init mid-frame SHALL abort the frame with no ack; any pending output byte is discarded.
REQ-027 init SHALL take priority over req in the same cycle.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, FRAME_LEN, ASCII_SPACE=8'h20, PRE_MIN=10 and PRE_MAX=15.
REQ-029 The LFSR SHALL be a separate sub-module, lfsr7, with ports clk, init, load, load_val, ptrn, adv and state.

Verification
REQ-030 Config ptrn=7'h60, init=7'h01, pre_length=10, message "A" with in_last, out_ready=1 SHALL produce:
- Bytes 0..2 = 0x81, 0x82, 0x84.
- Byte 10 = 0x39.
- Bytes 11..63 = encrypted spaces.
- ack pulses once.
REQ-031 lfsr_init=0 SHALL produce output identical to lfsr_init=7'h01.
REQ-032 pre_length=3 SHALL give the first message byte at position 10; pre_length=15 (the maximum) SHALL place it at position 15.
REQ-033 Toggling out_ready randomly SHALL leave out_data stable during stalls, with no byte lost or duplicated versus the golden model.
REQ-034 A 60-character message without in_last and pre_length=10 SHALL result in:
- Exactly 54 bytes accepted.
- in_ready=0 afterward.
- 64 bytes emitted, then ack.
REQ-035 init asserted at byte 30, then a new req, SHALL produce a complete fresh frame from lfsr[0] with no stale ack.
